// File: rtl/adc_baseline_cal.sv
// Per-channel ADC baseline calibration: averages 2**LOG2_FRAMES aligned 8-channel frames
// on request and holds the resulting baselines for the downstream correlation stage.
module adc_baseline_cal #(
    parameter int          LOG2_FRAMES  = 6,
    parameter logic [11:0] DEFAULT_BASE = 12'h800
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] measure_dataread,
    input  logic [2:0]  measure_fifo_ch,
    input  logic        adc_fifo_write_rq,
    input  logic        cal_start,
    output logic [17:0] b0,
    output logic [18:0] b1,
    output logic [17:0] b2,
    output logic [18:0] b3,
    output logic [17:0] b4,
    output logic [18:0] b5,
    output logic [17:0] b6,
    output logic [18:0] b7,
    output logic        cal_busy,
    output logic        cal_done,
    output logic        cal_valid
);

    localparam int ACC_W = 12 + LOG2_FRAMES;
    localparam int CNT_W = LOG2_FRAMES + 1;
    localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'((1 << LOG2_FRAMES) - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        ACCUM,
        LOAD
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [11:0]        sample_reg;
    logic [CNT_W-1:0]   frame_cnt_reg;
    logic               cal_done_reg;
    logic               cal_valid_reg;
    logic [2:0]         index;
    logic               acc_clear;
    logic               acc_en;
    logic               cnt_inc;
    logic               load_en;
    logic [11:0]        base_val [8];

    // Tag 0 lands on b6, tag 2 on b0: the 3-bit add wraps modulo 8.
    assign index = measure_fifo_ch + 3'd6;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // cal_start overrides everything, including a strobe in the same cycle.
    always_comb begin
        state_next = state_reg;
        acc_clear  = 1'b0;
        acc_en     = 1'b0;
        cnt_inc    = 1'b0;
        load_en    = 1'b0;
        if (cal_start) begin
            state_next = ARM;
            acc_clear  = 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next = IDLE;
                end
                ARM: begin
                    if (adc_fifo_write_rq && (measure_fifo_ch == 3'd0)) begin
                        state_next = ACCUM;
                        acc_en     = 1'b1;
                    end
                end
                ACCUM: begin
                    if (adc_fifo_write_rq) begin
                        acc_en = 1'b1;
                        if (measure_fifo_ch == 3'd7) begin
                            cnt_inc = 1'b1;
                            if (frame_cnt_reg == LAST_FRAME) begin
                                state_next = LOAD;
                            end
                        end
                    end
                end
                LOAD: begin
                    load_en    = 1'b1;
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign cal_busy = (state_reg == ARM) || (state_reg == ACCUM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_reg    <= 12'd0;
            frame_cnt_reg <= '0;
            cal_done_reg  <= 1'b0;
            cal_valid_reg <= 1'b0;
        end else begin
            sample_reg   <= measure_dataread;
            cal_done_reg <= load_en;
            if (load_en) begin
                cal_valid_reg <= 1'b1;
            end
            if (acc_clear) begin
                frame_cnt_reg <= '0;
            end else if (cnt_inc) begin
                frame_cnt_reg <= frame_cnt_reg + 1'b1;
            end
        end
    end

    assign cal_done  = cal_done_reg;
    assign cal_valid = cal_valid_reg;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_chan
            logic [ACC_W-1:0] acc_reg;
            logic [11:0]      base_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    acc_reg <= '0;
                end else if (acc_clear) begin
                    acc_reg <= '0;
                end else if (acc_en && (index == 3'(gi))) begin
                    acc_reg <= acc_reg + ACC_W'(sample_reg);
                end
            end

            // Dropping the low LOG2_FRAMES bits is the truncating divide by the frame count.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    base_reg <= DEFAULT_BASE;
                end else if (load_en) begin
                    base_reg <= acc_reg[ACC_W-1:LOG2_FRAMES];
                end
            end

            assign base_val[gi] = base_reg;
        end
    endgenerate

    assign b0 = {6'd0, base_val[0]};
    assign b1 = {7'd0, base_val[1]};
    assign b2 = {6'd0, base_val[2]};
    assign b3 = {7'd0, base_val[3]};
    assign b4 = {6'd0, base_val[4]};
    assign b5 = {7'd0, base_val[5]};
    assign b6 = {6'd0, base_val[6]};
    assign b7 = {7'd0, base_val[7]};

endmodule
